// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared types and constants for the ALU NOT-path checker
package alu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // One MISR step: shift left with polynomial feedback from the MSB, then fold in data.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? SIG_POLY : 16'h0000)) ^ din;
  endfunction

endpackage

// File: rtl/alu_chk_misr.sv
// rtl/alu_chk_misr.sv - 16-bit MISR compacting accepted results into a signature
import alu_chk_pkg::*;

module alu_chk_misr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [15:0]      sig
);

  logic [15:0] data_ext;

  assign data_ext = 16'(data);

  // Seed load wins over shift so a restart always begins from a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SIG_SEED;
    end else if (load) begin
      sig <= SIG_SEED;
    end else if (en) begin
      sig <= misr_step(sig, data_ext);
    end
  end

endmodule

// File: rtl/alu_not_checker.sv
// rtl/alu_not_checker.sv - response checker for the 4-bit NOT gate x/o vector stream
import alu_chk_pkg::*;

module alu_not_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_o,
  output logic [15:0]      signature
);

  state_e           state;
  logic [CNT_W-1:0] num_q;
  logic             accept;
  logic             mismatch;
  logic             last_vec;
  logic             launch;
  logic             err_sat;

  assign accept   = in_valid & in_ready;
  assign mismatch = (o != ~x);
  assign last_vec = (vec_count == num_q - CNT_W'(1));
  assign err_sat  = (err_count == {CNT_W{1'b1}});
  // start is only honoured between runs; during RUN it is ignored.
  assign launch   = start & (state != RUN);

  alu_chk_misr #(.WIDTH(WIDTH)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .en    (accept),
    .data  (o),
    .sig   (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_q         <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_x   <= '0;
      first_err_o   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_q         <= num_vecs;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_x   <= '0;
            first_err_o   <= '0;
            if (num_vecs == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              pass     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            vec_count <= vec_count + CNT_W'(1);
            if (mismatch) begin
              if (!err_sat) begin
                err_count <= err_count + CNT_W'(1);
              end
              if (err_count == '0) begin
                first_err_idx <= vec_count;
                first_err_x   <= x;
                first_err_o   <= o;
              end
            end
            // pass must account for a mismatch on the very last vector.
            if (last_vec) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_count == '0) && !mismatch;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_not_checker.md
# alu_not_checker

Synthesizable response checker for the integer ALU's 4-bit NOT gate path: the consuming end of the x/o vector stream that stimulus benches drive. Accepts operand/result pairs over a valid/ready handshake, compares each result against the bitwise inverse of its operand, and counts vectors and mismatches. It also records the first failure and folds every result into a 16-bit signature, giving on-chip or at-speed runs a single pass/fail view.

## Interface
- WIDTH, 4, operand/result width
- CNT_W, 8, width of vector/error counters and num_vecs
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches num_vecs, clears all results, begins run
- num_vecs  in  CNT_W  number of vectors in the run, sampled on start
- in_valid  in  1  x/o pair is valid
- in_ready  out  1  checker can accept a pair
- x  in  WIDTH  operand applied to the gate
- o  in  WIDTH  result produced by the gate
- busy  out  1  run in progress
- done  out  1  run complete; results stable
- pass  out  1  done and zero mismatches
- vec_count  out  CNT_W  vectors accepted this run
- err_count  out  CNT_W  mismatches this run, saturating
- first_err_idx  out  CNT_W  vec_count value of first mismatch
- first_err_x  out  WIDTH  operand of first mismatch
- first_err_o  out  WIDTH  result of first mismatch
- signature  out  16  MISR over accepted results

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0. start with num_vecs!=0 -> RUN; start with num_vecs==0 -> DONE (pass=1, signature=seed).
- RUN: in_ready=1. Accept = in_valid & in_ready. Per accept: vec_count+1; if o != ~x then err_count+1 (saturates at all-ones), and if err_count==0 capture first_err_* (idx = vec_count before increment).
- Signature per accept: sig <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ zero-extended o. Seed 16'hFFFF, loaded on start.
- Accept of vector num_vecs-1 -> DONE on the same edge.
- DONE: in_ready=0, outputs hold. start -> clears results, same rules as in IDLE.
- start during RUN ignored; run continues.
- in_valid outside RUN ignored; no counters change.
- x/o values with in_valid low are don't-care.

## Timing
- Reset: state IDLE; in_ready, busy, done, pass = 0; all counters, first_err_* = 0; signature = 16'hFFFF.
- Reset mid-run aborts immediately to reset values; no partial results retained.
- in_ready is a function of state only (no combinational path from in_valid).
- Counters, signature, first_err_* update on the edge of the accepting cycle; visible the next cycle.
- done rises the cycle after the final accept; pass = done & (err_count==0), registered alongside.
- start to in_ready high: 1 cycle. Throughput: one vector per cycle.
- Back-to-back: start in DONE clears results and returns to RUN with in_ready high the next cycle.

## Structure
- Package alu_chk_pkg: state enum (IDLE, RUN, DONE), SIG_POLY = 16'h1021, SIG_SEED = 16'hFFFF.
- Sub-module alu_chk_misr: 16-bit MISR with load-seed and enable-shift inputs, WIDTH-bit data in.
- Top: FSM, counters, first-fail capture, compare.

## Test plan
- Reset then idle: in_valid=1, x=4'b0110 for 5 cycles -> in_ready=0, vec_count=0, signature=16'hFFFF.
- start, num_vecs=3; send (0000,1111), (0110,1001), (1111,0000) back-to-back -> done 1 cycle after third accept, vec_count=3, err_count=0, pass=1, signature matches bench model.
- start, num_vecs=3; second pair (0110,0110) and third (1111,0001) wrong -> err_count=2, first_err_idx=1, first_err_x=0110, first_err_o=0110, pass=0.
- start, num_vecs=0 -> done=1, pass=1 next cycle; in_ready stays 0.
- num_vecs=4, gap in_valid low 3 cycles between vectors, pulse start mid-run -> start ignored, vec_count=4 at done.
- rst_n low after 2 of 4 vectors -> all outputs at reset values same cycle; new start runs cleanly from zero.
